// File: rtl/cordic_rr_scheduler.sv
// cordic_rr_scheduler: round-robin front end that shares one pipelined CORDIC
// vectoring core among NUM_REQ requesters. Each issued sample carries a tag
// (valid + source id) through a delay line matched to the core, so results
// come back to the right requester PIPE_LAT+1 cycles after the grant.
// Optional feature macro: CORDIC_SCHED_STATS_EN (issue/done counters + stat_clr).
module cordic_rr_scheduler #(
    parameter int DATA_WIDTH = 15,
    parameter int NUM_REQ    = 4,
    parameter int PIPE_LAT   = 13
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_X,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_Y,
    output logic [DATA_WIDTH-1:0]            cordic_in_X,
    output logic [DATA_WIDTH-1:0]            cordic_in_Y,
    input  logic [DATA_WIDTH-1:0]            cordic_X,
    input  logic [DATA_WIDTH-1:0]            cordic_Y,
    input  logic [DATA_WIDTH-1:0]            cordic_th,
    output logic                             rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
    output logic [DATA_WIDTH-1:0]            rsp_X,
    output logic [DATA_WIDTH-1:0]            rsp_Y,
    output logic [DATA_WIDTH-1:0]            rsp_theta,
    output logic                             busy
`ifdef CORDIC_SCHED_STATS_EN
    ,
    input  logic                             stat_clr,
    output logic [31:0]                      stat_issued,
    output logic [31:0]                      stat_done
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ID_W-1:0]      ptr;
    logic                 grant_any;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W-1:0]      idx;

    // The issue register travels with cordic_in_X/Y; the core captures those
    // one edge later, so tag_v/tag_id below are the PIPE_LAT stages that line
    // up with the core's own stages and tag_v[PIPE_LAT-1] meets its outputs.
    logic                 issue_v;
    logic [ID_W-1:0]      issue_id;
    logic [PIPE_LAT-1:0]  tag_v;
    logic [ID_W-1:0]      tag_id [PIPE_LAT];
    logic                 any_tag;

    assign any_tag = issue_v | (|tag_v);
    assign busy    = any_tag | (state != IDLE);

    // Round-robin grant: first valid requester at or after ptr, RUN only
    always_comb begin
        req_ready = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        if (state == RUN) begin
            for (int unsigned o = 0; o < NUM_REQ; o++) begin
                idx = ID_W'((32'(ptr) + o) % NUM_REQ);
                if (!grant_any && req_valid[idx]) begin
                    grant_any      = 1'b1;
                    grant_id       = idx;
                end
            end
            if (grant_any) begin
                req_ready[grant_id] = 1'b1;
            end
        end
    end

    // Next-state logic for the enable/drain control FSM
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = DRAIN;
            DRAIN: begin
                if (enable)        state_nxt = RUN;
                else if (!any_tag) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Issue stage: register the granted sample (or a zero bubble) and advance ptr
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= '0;
            cordic_in_X <= '0;
            cordic_in_Y <= '0;
            issue_v     <= 1'b0;
            issue_id    <= '0;
        end else begin
            issue_v  <= grant_any;
            issue_id <= grant_id;
            if (grant_any) begin
                cordic_in_X <= req_X[grant_id*DATA_WIDTH +: DATA_WIDTH];
                cordic_in_Y <= req_Y[grant_id*DATA_WIDTH +: DATA_WIDTH];
                ptr         <= (32'(grant_id) == 32'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end else begin
                cordic_in_X <= '0;
                cordic_in_Y <= '0;
            end
        end
    end

    // Tag delay line matching the core latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v <= '0;
            for (int unsigned i = 0; i < PIPE_LAT; i++) tag_id[i] <= '0;
        end else begin
            tag_v     <= {tag_v[PIPE_LAT-2:0], issue_v};
            tag_id[0] <= issue_id;
            for (int unsigned i = 1; i < PIPE_LAT; i++) tag_id[i] <= tag_id[i-1];
        end
    end

    // Response register: capture core outputs when a tagged sample emerges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_X     <= '0;
            rsp_Y     <= '0;
            rsp_theta <= '0;
        end else begin
            rsp_valid <= tag_v[PIPE_LAT-1];
            if (tag_v[PIPE_LAT-1]) begin
                rsp_id    <= tag_id[PIPE_LAT-1];
                rsp_X     <= cordic_X;
                rsp_Y     <= cordic_Y;
                rsp_theta <= cordic_th;
            end
        end
    end

`ifdef CORDIC_SCHED_STATS_EN
    // Issue/completion counters; clear wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_issued <= '0;
            stat_done   <= '0;
        end else if (stat_clr) begin
            stat_issued <= '0;
            stat_done   <= '0;
        end else begin
            if (grant_any)          stat_issued <= stat_issued + 32'd1;
            if (tag_v[PIPE_LAT-1])  stat_done   <= stat_done + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Testbench for cordic_rr_scheduler. A behavioural stand-in for the CORDIC
// core (magnitude, x^y residual, atan2 in Q2.12) sits on the core ports; a
// scoreboard of accepted samples predicts every response and its due cycle.
module tb_cordic_rr_scheduler;

    localparam int DW = 15;
    localparam int NR = 4;
    localparam int PL = 13;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_X;
    logic [NR*DW-1:0]  req_Y;
    logic [DW-1:0]     cordic_in_X, cordic_in_Y;
    logic [DW-1:0]     cordic_X, cordic_Y, cordic_th;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_X, rsp_Y, rsp_theta;
    logic              busy;
`ifdef CORDIC_SCHED_STATS_EN
    logic              stat_clr;
    logic [31:0]       stat_issued, stat_done;
`endif

    cordic_rr_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_X(req_X), .req_Y(req_Y),
        .cordic_in_X(cordic_in_X), .cordic_in_Y(cordic_in_Y),
        .cordic_X(cordic_X), .cordic_Y(cordic_Y), .cordic_th(cordic_th),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_X(rsp_X), .rsp_Y(rsp_Y), .rsp_theta(rsp_theta),
        .busy(busy)
`ifdef CORDIC_SCHED_STATS_EN
        , .stat_clr(stat_clr), .stat_issued(stat_issued), .stat_done(stat_done)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in core result for one input sample: {magnitude, x^y, angle}
    function automatic logic [3*DW-1:0] core_fn(input logic [DW-1:0] x, input logic [DW-1:0] y);
        real rx, ry;
        int  mag, th;
        rx  = real'($signed(x));
        ry  = real'($signed(y));
        mag = int'($sqrt(rx * rx + ry * ry));
        th  = int'($atan2(ry, rx) * 4096.0);
        return {DW'(mag), x ^ y, DW'(th)};
    endfunction

    logic [3*DW-1:0] core_pipe [PL];
    always @(posedge clk) begin
        core_pipe[0] <= core_fn(cordic_in_X, cordic_in_Y);
        for (int i = 1; i < PL; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign {cordic_X, cordic_Y, cordic_th} = core_pipe[PL-1];

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
    } pend_t;

    typedef struct {
        logic          en;
        logic [NR-1:0] rv;
        logic [NR-1:0] rdy;
    } vec_t;

    pend_t           pend[$];
    int              obs_ids[$];
    int              n_tests = 0;
    int              n_fail  = 0;
    int              cyc     = 0;
    int              m_mode  = 0;   // 0 idle, 1 granting, 2 draining
    int              m_ptr   = 0;
    int              n_acc   = 0;
    int              rsp_count = 0;
    int              last_acc_cyc = 0;
    int              last_rsp_cyc = 0;
    logic [3*DW-1:0] last_r = '0;
    logic [NR-1:0]   obs_grant;
    logic [DW-1:0]   obs_theta;
    int              obs_id;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] rnd_s();
        int v;
        v = int'($urandom_range(16000, 0)) - 8000;
        return DW'(v);
    endfunction

    task automatic rnd_data();
        for (int i = 0; i < NR; i++) begin
            req_X[i*DW +: DW] = rnd_s();
            req_Y[i*DW +: DW] = rnd_s();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_in_X"}, cordic_in_X, 0);
        check({tag, "_in_Y"}, cordic_in_Y, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_rsp_X"}, rsp_X, 0);
        check({tag, "_rsp_Y"}, rsp_Y, 0);
        check({tag, "_rsp_theta"}, rsp_theta, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // One clock cycle: inputs already applied (called just after a negedge)
    task automatic step(input logic use_tbl, input logic [NR-1:0] tbl_ready);
        logic [NR-1:0]   exp_ready;
        logic [DW-1:0]   ex_x, ex_y;
        logic [3*DW-1:0] r;
        logic [IW-1:0]   idx;
        logic            empty;
        int              g;
        exp_ready = '0;
        g = -1;
        if (m_mode == 1) begin
            for (int o = 0; o < NR; o++) begin
                idx = IW'((m_ptr + o) % NR);
                if (g < 0 && req_valid[idx]) g = int'(idx);
            end
        end
        if (g >= 0) exp_ready = NR'(1) << g;
        empty = (pend.size() == 0);
        #1;
        obs_grant = req_ready;
        check("req_ready", req_ready, exp_ready);
        if (use_tbl) check("tbl_ready", req_ready, tbl_ready);
        @(posedge clk);
        cyc++;
        ex_x = '0;
        ex_y = '0;
        if (g >= 0) begin
            ex_x = req_X[g*DW +: DW];
            ex_y = req_Y[g*DW +: DW];
            pend.push_back('{cyc + PL + 1, g, ex_x, ex_y});
            m_ptr = (g + 1) % NR;
            last_acc_cyc = cyc;
            n_acc++;
        end
        case (m_mode)
            0: if (enable) m_mode = 1;
            1: if (!enable) m_mode = 2;
            default: begin
                if (enable) m_mode = 1;
                else if (empty) m_mode = 0;
            end
        endcase
        @(negedge clk);
        check("cordic_in_X", cordic_in_X, ex_x);
        check("cordic_in_Y", cordic_in_Y, ex_y);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = core_fn(pend[0].x, pend[0].y);
            check("rsp_valid", rsp_valid, 1'b1);
            check("rsp_id", rsp_id, pend[0].id);
            check("rsp_X", rsp_X, r[3*DW-1:2*DW]);
            check("rsp_Y", rsp_Y, r[2*DW-1:DW]);
            check("rsp_theta", rsp_theta, r[DW-1:0]);
            last_r = r;
            void'(pend.pop_front());
        end else begin
            check("rsp_valid_idle", rsp_valid, 1'b0);
            check("rsp_hold", {rsp_X, rsp_Y, rsp_theta}, last_r);
        end
        if (rsp_valid) begin
            rsp_count++;
            last_rsp_cyc = cyc;
            obs_theta = rsp_theta;
            obs_id = int'(rsp_id);
            obs_ids.push_back(int'(rsp_id));
        end
        check("busy", busy, (m_mode != 0) || (pend.size() > 0));
    endtask

    task automatic drain(input string name);
        enable    = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 60 && busy; i++) step(1'b0, '0);
        check(name, busy, 1'b0);
    endtask

    vec_t vecs[16];
    int   base;
    int   th;

    initial begin
        vecs[0]  = '{1'b1, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0001};
        vecs[2]  = '{1'b1, 4'b1111, 4'b0010};
        vecs[3]  = '{1'b1, 4'b1111, 4'b0100};
        vecs[4]  = '{1'b1, 4'b1001, 4'b1000};
        vecs[5]  = '{1'b1, 4'b1001, 4'b0001};
        vecs[6]  = '{1'b1, 4'b1010, 4'b0010};
        vecs[7]  = '{1'b1, 4'b1010, 4'b1000};
        vecs[8]  = '{1'b1, 4'b1001, 4'b0001};
        vecs[9]  = '{1'b1, 4'b0001, 4'b0001};
        vecs[10] = '{1'b1, 4'b0000, 4'b0000};
        vecs[11] = '{1'b1, 4'b0110, 4'b0010};
        vecs[12] = '{1'b0, 4'b1111, 4'b0100};
        vecs[13] = '{1'b0, 4'b1111, 4'b0000};
        vecs[14] = '{1'b1, 4'b1111, 4'b0000};
        vecs[15] = '{1'b1, 4'b1111, 4'b1000};

        rst = 1'b0;
        enable = 1'b0;
        req_valid = '0;
        req_X = '0;
        req_Y = '0;
`ifdef CORDIC_SCHED_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // Grant table: rotation, wrap, enable fall with accept, drain/resume
        foreach (vecs[i]) begin
            enable = vecs[i].en;
            req_valid = vecs[i].rv;
            rnd_data();
            step(1'b1, vecs[i].rdy);
        end
        drain("tbl_drain");

        // Single sample (4096, 0) from requester 0
        enable = 1'b1;
        req_valid = '0;
        step(1'b0, '0);
        req_valid = 4'b0001;
        req_X = '0;
        req_Y = '0;
        req_X[DW-1:0] = DW'(4096);
        step(1'b0, '0);
        base = rsp_count;
        req_valid = '0;
        for (int i = 0; i < 30 && rsp_count == base; i++) step(1'b0, '0);
        check("t2_got_rsp", rsp_count - base, 1);
        check("t2_latency", last_rsp_cyc - last_acc_cyc, PL + 1);
        check("t2_id", obs_id, 0);
        th = int'($signed(obs_theta));
        check("t2_theta_near0", (th >= -4 && th <= 4), 1'b1);

        // Fairness: park ptr at 0, then all valid for 8 cycles
        req_valid = 4'b1000;
        step(1'b0, '0);
        drain("t3_pre_drain");
        enable = 1'b1;
        req_valid = '0;
        step(1'b0, '0);
        obs_ids.delete();
        for (int k = 0; k < 8; k++) begin
            req_valid = 4'b1111;
            rnd_data();
            step(1'b0, '0);
            check("t3_grant", obs_grant, NR'(1) << (k % NR));
        end
        drain("t3_drain");
        check("t3_rsp_count", obs_ids.size(), 8);
        for (int k = 0; k < 8 && k < obs_ids.size(); k++) check("t3_rsp_id", obs_ids[k], k % NR);

        // Drain: 5 accepts, the last one coinciding with enable falling
        enable = 1'b1;
        req_valid = '0;
        step(1'b0, '0);
        base = rsp_count;
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            enable = (k < 4);
            req_valid = 4'b1111;
            rnd_data();
            step(1'b0, '0);
        end
        check("t5_accepts", n_acc, 5);
        step(1'b0, '0);
        check("t5_ready_off", obs_grant, 0);
        for (int i = 0; i < 40 && busy; i++) step(1'b0, '0);
        check("t5_delivered", rsp_count - base, 5);
        check("t5_idle", busy, 1'b0);

        // Randomised traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(9, 0) != 0);
            req_valid = NR'($urandom);
            rnd_data();
            step(1'b0, '0);
        end

        // Reset in the middle of traffic
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_valid = 4'b1111;
            rnd_data();
            step(1'b0, '0);
        end
        #2 rst = 1'b0;
        #1 check_all_zero("t1_midreset");
        pend.delete();
        m_mode = 0;
        m_ptr = 0;
        last_r = '0;
        @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        req_valid = '0;
        base = rsp_count;
        repeat (PL + 4) step(1'b0, '0);
        check("t1_no_stale_rsp", rsp_count - base, 0);
        enable = 1'b1;
        step(1'b0, '0);
        req_valid = 4'b0010;
        rnd_data();
        step(1'b0, '0);
        req_valid = '0;
        repeat (PL + 3) step(1'b0, '0);
        check("t1_new_rsp", rsp_count - base, 1);
        check("t1_new_id", obs_id, 1);
        drain("t1_drain");

`ifdef CORDIC_SCHED_STATS_EN
        stat_clr = 1'b1;
        step(1'b0, '0);
        stat_clr = 1'b0;
        check("t6_clr_issued", stat_issued, 0);
        check("t6_clr_done", stat_done, 0);
        enable = 1'b1;
        step(1'b0, '0);
        for (int k = 0; k < 10; k++) begin
            enable = (k < 9);
            req_valid = 4'b1111;
            rnd_data();
            step(1'b0, '0);
        end
        drain("t6_drain");
        check("t6_issued", stat_issued, 10);
        check("t6_done", stat_done, 10);
        stat_clr = 1'b1;
        step(1'b0, '0);
        stat_clr = 1'b0;
        check("t6_clr2_issued", stat_issued, 0);
        check("t6_clr2_done", stat_done, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
